// File: rtl/whack_mole_renderer_if.sv
// Request and pixel-write bundle between the game control logic (master)
// and the board renderer (slave) that feeds the VGA adapter write port.
interface whack_mole_renderer_if #(
  parameter int XW = 9,
  parameter int YW = 8
);
  logic          start;
  logic          hole_valid;
  logic [3:0]    hole;
  logic          busy;
  logic          done;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [2:0]    color;
  logic          plot;

  modport master (
    output start, hole_valid, hole,
    input  busy, done, x, y, color, plot
  );

  modport slave (
    input  start, hole_valid, hole,
    output busy, done, x, y, color, plot
  );
endinterface

// File: rtl/whack_mole_renderer.sv
// Whac-A-Mole board renderer: streams one pixel per clock into the VGA frame
// buffer to draw the background with its row of holes, and to erase, draw
// and move the mole between holes. Requests arriving mid-job are queued.
module whack_mole_renderer #(
  parameter int          SCREEN_W   = 320,
  parameter int          SCREEN_H   = 240,
  parameter int          XW         = 9,
  parameter int          YW         = 8,
  parameter int          NUM_HOLES  = 8,
  parameter int          HOLE_X0    = 8,
  parameter int          HOLE_PITCH = 38,
  parameter int          HOLE_W     = 31,
  parameter int          HOLE_H     = 31,
  parameter int          HOLE_Y0    = 110,
  parameter int          MOLE_INSET = 4,
  parameter logic [2:0]  COLOR_BG   = 3'd0,
  parameter logic [2:0]  COLOR_HOLE = 3'd1,
  parameter logic [2:0]  COLOR_MOLE = 3'd6
) (
  input  logic                 clk,
  input  logic                 rst,
  whack_mole_renderer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, BG, ERASE, MOLE, FIN} state_t;

  localparam logic [XW-1:0] X_LAST    = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(SCREEN_H - 1);
  localparam logic [XW-1:0] HOLE_X0_C = XW'(HOLE_X0);
  localparam logic [XW-1:0] PITCH     = XW'(HOLE_PITCH);
  localparam logic [XW-1:0] HOLE_SPAN = XW'(HOLE_W - 1);
  localparam logic [XW-1:0] INSET     = XW'(MOLE_INSET);
  localparam logic [XW-1:0] MOLE_SPAN = XW'(HOLE_W - 1 - 2 * MOLE_INSET);
  localparam logic [YW-1:0] HOLE_TOP  = YW'(HOLE_Y0);
  localparam logic [YW-1:0] HOLE_BOT  = YW'(HOLE_Y0 + HOLE_H - 1);
  localparam logic [YW-1:0] MOLE_TOP  = YW'(HOLE_Y0 + MOLE_INSET);
  localparam logic [YW-1:0] MOLE_BOT  = YW'(HOLE_Y0 + HOLE_H - 1 - MOLE_INSET);

  // Left edge of hole k (1-based) built as a chain of pitch additions.
  function automatic logic [XW-1:0] hole_left(input logic [3:0] k);
    logic [XW-1:0] left;
    left = HOLE_X0_C;
    for (int i = 2; i <= 15; i++) begin
      if (i <= int'(k)) left = left + PITCH;
    end
    return left;
  endfunction

  // True when pixel (px,py) lies in the hole whose left edge / index is given.
  function automatic logic in_hole(input logic [XW-1:0] px, input logic [YW-1:0] py,
                                   input logic [XW-1:0] left, input logic [3:0] idx);
    return (int'(idx) < NUM_HOLES) && (px >= left) && (px <= left + HOLE_SPAN) &&
           (py >= HOLE_TOP) && (py <= HOLE_BOT);
  endfunction

  state_t        state;
  logic [3:0]    cur_hole;
  logic [3:0]    new_hole;
  logic [3:0]    pend_hole;
  logic          pend_start;
  logic          pend_hole_v;
  logic [XW-1:0] rx0;
  logic [XW-1:0] rx1;
  logic [YW-1:0] ry1;
  logic [XW-1:0] bg_left;
  logic [3:0]    bg_idx;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [2:0]    color_q;
  logic          plot_q;
  logic          busy_q;
  logic          done_q;

  logic [3:0]    hole_in;
  logic          eff_start;
  logic          eff_hole_v;
  logic [3:0]    req_hole;
  logic          row_end;
  logic          last_px;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic [XW-1:0] ne;
  logic [3:0]    ni;
  logic [2:0]    bg_color_nx;
  logic [2:0]    bg_color_0;
  logic [3:0]    mole_hole;
  logic [XW-1:0] mole_left;
  logic [XW-1:0] cur_left;

  // Request merging, next raster position, background colour and rectangle edges.
  always_comb begin
    // NOTE: every signal below gets a value on every path before any condition, so no latch is inferred.
    hole_in    = (int'(bus.hole) > NUM_HOLES) ? 4'd0 : bus.hole;
    eff_start  = bus.start | pend_start;
    eff_hole_v = bus.hole_valid | pend_hole_v;
    req_hole   = bus.hole_valid ? hole_in : pend_hole;

    row_end = (x_q == rx1);
    last_px = row_end && (y_q == ry1);
    nx      = row_end ? rx0 : x_q + XW'(1);
    ny      = row_end ? y_q + YW'(1) : y_q;

    // The tracked hole advances once the scan leaves its right edge and
    // restarts at the first hole on every new row.
    ne = bg_left;
    ni = bg_idx;
    if (nx == '0) begin
      ne = HOLE_X0_C;
      ni = 4'd0;
    end else if ((x_q == bg_left + HOLE_SPAN) && (int'(bg_idx) < NUM_HOLES)) begin
      ne = bg_left + PITCH;
      ni = bg_idx + 4'd1;
    end
    bg_color_nx = in_hole(nx, ny, ne, ni) ? COLOR_HOLE : COLOR_BG;
    bg_color_0  = in_hole('0, '0, HOLE_X0_C, 4'd0) ? COLOR_HOLE : COLOR_BG;

    // The mole that starts next belongs to a different hole in each state.
    case (state)
      BG:      mole_hole = cur_hole;
      ERASE:   mole_hole = new_hole;
      default: mole_hole = req_hole;
    endcase
    mole_left = hole_left(mole_hole) + INSET;
    cur_left  = hole_left(cur_hole);
  end

  // Control FSM with registered pixel outputs; each job chains without bubbles.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state       <= IDLE;
      cur_hole    <= 4'd0;
      new_hole    <= 4'd0;
      pend_hole   <= 4'd0;
      pend_start  <= 1'b0;
      pend_hole_v <= 1'b0;
      rx0         <= '0;
      rx1         <= '0;
      ry1         <= '0;
      bg_left     <= '0;
      bg_idx      <= 4'd0;
      x_q         <= '0;
      y_q         <= '0;
      color_q     <= 3'd0;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (state inside {BG, ERASE, MOLE}) begin
        if (bus.start) pend_start <= 1'b1;
        if (bus.hole_valid) begin
          pend_hole_v <= 1'b1;
          pend_hole   <= hole_in;
        end
      end

      case (state)
        IDLE, FIN: begin
          // Dispatch always consumes everything outstanding.
          pend_start  <= 1'b0;
          pend_hole_v <= 1'b0;
          if (eff_start) begin
            if (eff_hole_v) cur_hole <= req_hole;
            state   <= BG;
            rx0     <= '0;
            rx1     <= X_LAST;
            ry1     <= Y_LAST;
            x_q     <= '0;
            y_q     <= '0;
            bg_left <= HOLE_X0_C;
            bg_idx  <= 4'd0;
            color_q <= bg_color_0;
            plot_q  <= 1'b1;
            busy_q  <= 1'b1;
          end else if (eff_hole_v) begin
            if (req_hole == cur_hole) begin
              state  <= FIN;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              plot_q <= 1'b0;
            end else if (cur_hole != 4'd0) begin
              state    <= ERASE;
              new_hole <= req_hole;
              rx0      <= cur_left;
              rx1      <= cur_left + HOLE_SPAN;
              ry1      <= HOLE_BOT;
              x_q      <= cur_left;
              y_q      <= HOLE_TOP;
              color_q  <= COLOR_HOLE;
              plot_q   <= 1'b1;
              busy_q   <= 1'b1;
            end else if (req_hole != 4'd0) begin
              state    <= MOLE;
              cur_hole <= req_hole;
              rx0      <= mole_left;
              rx1      <= mole_left + MOLE_SPAN;
              ry1      <= MOLE_BOT;
              x_q      <= mole_left;
              y_q      <= MOLE_TOP;
              color_q  <= COLOR_MOLE;
              plot_q   <= 1'b1;
              busy_q   <= 1'b1;
            end else begin
              state  <= FIN;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              plot_q <= 1'b0;
            end
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
            plot_q <= 1'b0;
          end
        end

        BG: begin
          if (!last_px) begin
            x_q     <= nx;
            y_q     <= ny;
            bg_left <= ne;
            bg_idx  <= ni;
            color_q <= bg_color_nx;
          end else if (cur_hole != 4'd0) begin
            state   <= MOLE;
            rx0     <= mole_left;
            rx1     <= mole_left + MOLE_SPAN;
            ry1     <= MOLE_BOT;
            x_q     <= mole_left;
            y_q     <= MOLE_TOP;
            color_q <= COLOR_MOLE;
          end else begin
            state  <= FIN;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            plot_q <= 1'b0;
          end
        end

        ERASE: begin
          if (!last_px) begin
            x_q <= nx;
            y_q <= ny;
          end else begin
            cur_hole <= new_hole;
            if (new_hole != 4'd0) begin
              state   <= MOLE;
              rx0     <= mole_left;
              rx1     <= mole_left + MOLE_SPAN;
              ry1     <= MOLE_BOT;
              x_q     <= mole_left;
              y_q     <= MOLE_TOP;
              color_q <= COLOR_MOLE;
            end else begin
              state  <= FIN;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              plot_q <= 1'b0;
            end
          end
        end

        MOLE: begin
          if (!last_px) begin
            x_q <= nx;
            y_q <= ny;
          end else begin
            state  <= FIN;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            plot_q <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          plot_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x     = x_q;
  assign bus.y     = y_q;
  assign bus.color = color_q;
  assign bus.plot  = plot_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_whack_mole_renderer.sv
// Scoreboard bench for whack_mole_renderer on a reduced board (192x40, five
// holes at y 4..34) so that several full redraws stay short. Stimulus pushes
// the expected pixel stream and done markers; the monitor pops and compares.
module tb_whack_mole_renderer;

  localparam int SW  = 192;
  localparam int SH  = 40;
  localparam int NH  = 5;
  localparam int X0  = 8;
  localparam int P   = 38;
  localparam int HW  = 31;
  localparam int HH  = 31;
  localparam int Y0  = 4;
  localparam int INS = 4;
  localparam int BGN = SW * SH;

  typedef struct {
    bit is_done;
    int x;
    int y;
    int c;
  } ev_t;

  logic clk = 1'b0;
  logic rst;

  whack_mole_renderer_if #(.XW(9), .YW(8)) bus ();

  whack_mole_renderer #(
    .SCREEN_W (SW),
    .SCREEN_H (SH),
    .NUM_HOLES(NH),
    .HOLE_Y0  (Y0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  ev_t      exp_q[$];
  int       total = 0;
  int       bad = 0;
  int       job_err = 0;
  int       job_busy = 0;
  int       jobs_done = 0;
  int       last_x = -1;
  int       last_y = -1;
  logic [2:0] fb [SH][SW];

  task automatic check(input string name, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  function automatic int hole_left(input int k);
    return X0 + (k - 1) * P;
  endfunction

  function automatic bit model_in_hole(input int px, input int py);
    if (px < X0 || py < Y0 || py > Y0 + HH - 1) return 1'b0;
    return ((px - X0) / P < NH) && ((px - X0) % P < HW);
  endfunction

  function automatic void push_px(input int px, input int py, input int c);
    ev_t e;
    e.is_done = 1'b0;
    e.x = px;
    e.y = py;
    e.c = c;
    exp_q.push_back(e);
  endfunction

  function automatic void push_rect(input int xa, input int xb, input int ya, input int yb, input int c);
    for (int py = ya; py <= yb; py++)
      for (int px = xa; px <= xb; px++)
        push_px(px, py, c);
  endfunction

  function automatic void push_bg();
    for (int py = 0; py < SH; py++)
      for (int px = 0; px < SW; px++)
        push_px(px, py, model_in_hole(px, py) ? 1 : 0);
  endfunction

  function automatic void push_erase(input int k);
    push_rect(hole_left(k), hole_left(k) + HW - 1, Y0, Y0 + HH - 1, 1);
  endfunction

  function automatic void push_mole(input int k);
    push_rect(hole_left(k) + INS, hole_left(k) + HW - 1 - INS, Y0 + INS, Y0 + HH - 1 - INS, 6);
  endfunction

  // The done marker carries the number of busy cycles the job must take.
  function automatic void push_done(input int busy_cycles);
    ev_t e;
    e.is_done = 1'b1;
    e.x = busy_cycles;
    e.y = 0;
    e.c = 0;
    exp_q.push_back(e);
  endfunction

  task automatic pulse(input bit st, input bit hv, input logic [3:0] h);
    @(negedge clk);
    bus.start      = st;
    bus.hole_valid = hv;
    bus.hole       = h;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    bus.hole_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, " leftover events"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: compares every plotted pixel and every done pulse against the queue.
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.busy) job_busy++;
        if (bus.plot !== bus.busy) job_err++;
        if (bus.plot) begin
          if (int'(bus.x) < SW && int'(bus.y) < SH) fb[bus.y][bus.x] = bus.color;
          last_x = int'(bus.x);
          last_y = int'(bus.y);
          if (exp_q.size() == 0 || exp_q[0].is_done) begin
            job_err++;
          end else begin
            e = exp_q.pop_front();
            if (int'(bus.x) != e.x || int'(bus.y) != e.y || int'(bus.color) != e.c) job_err++;
          end
        end
        if (bus.done) begin
          while (exp_q.size() != 0 && !exp_q[0].is_done) begin
            void'(exp_q.pop_front());
            job_err++;
          end
          if (exp_q.size() == 0) begin
            check("unexpected done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            jobs_done++;
            check($sformatf("job%0d pixel errors", jobs_done), job_err, 0);
            check($sformatf("job%0d busy cycles", jobs_done), job_busy, e.x);
          end
          job_err  = 0;
          job_busy = 0;
        end
      end
    end
  end

  initial begin : stim
    for (int py = 0; py < SH; py++)
      for (int px = 0; px < SW; px++)
        fb[py][px] = 3'd7;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.hole_valid = 1'b0;
    bus.hole       = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset plot", bus.plot, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);

    // Reset in the middle of a redraw, with queued requests outstanding.
    push_bg();
    push_done(BGN);
    pulse(1'b1, 1'b0, 4'd0);
    repeat (300) @(negedge clk);
    pulse(1'b0, 1'b1, 4'd2);
    pulse(1'b1, 1'b0, 4'd0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid-job reset x", bus.x, 0);
    check("mid-job reset y", bus.y, 0);
    check("mid-job reset color", bus.color, 0);
    check("mid-job reset plot", bus.plot, 0);
    check("mid-job reset busy", bus.busy, 0);
    check("mid-job reset done", bus.done, 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    job_err  = 0;
    job_busy = 0;
    rst      = 1'b0;
    repeat (5) @(negedge clk);
    check("pending cleared by reset", bus.busy, 0);

    // Full board with no mole.
    push_bg();
    push_done(BGN);
    pulse(1'b1, 1'b0, 4'd0);
    check("board first x", bus.x, 0);
    check("board first y", bus.y, 0);
    check("board first plot", bus.plot, 1);
    wait_idle("board", BGN + 50);
    check("board last x", last_x, SW - 1);
    check("board last y", last_y, SH - 1);
    check("pix 8,4", fb[4][8], 1);
    check("pix 190,34", fb[34][190], 1);
    check("pix 39,4", fb[4][39], 0);
    check("pix 7,20", fb[20][7], 0);
    check("pix 38,34", fb[34][38], 1);
    check("pix 45,4", fb[4][45], 0);
    check("pix 46,4", fb[4][46], 1);
    check("pix 8,35", fb[35][8], 0);
    check("pix 191,39", fb[39][191], 0);

    // Mole into hole 3 from empty.
    push_mole(3);
    push_done(529);
    pulse(1'b0, 1'b1, 4'd3);
    check("mole3 first x", bus.x, 88);
    check("mole3 first y", bus.y, 8);
    check("mole3 first color", bus.color, 6);
    wait_idle("mole3", 600);
    check("pix 110,30 mole", fb[30][110], 6);
    check("pix 111,30 hole", fb[30][111], 1);

    // Move 3 -> 5, invalid 12 clears, then no-change requests.
    push_erase(3);
    push_mole(5);
    push_done(1490);
    pulse(1'b0, 1'b1, 4'd5);
    wait_idle("move 3to5", 1600);
    check("pix 88,8 erased", fb[8][88], 1);
    check("pix 186,30 mole", fb[30][186], 6);
    push_erase(5);
    push_done(961);
    pulse(1'b0, 1'b1, 4'd12);
    wait_idle("clear via 12", 1100);
    push_done(0);
    pulse(1'b0, 1'b1, 4'd0);
    check("same-hole no plot", bus.plot, 0);
    check("same-hole done", bus.done, 1);
    wait_idle("same 0", 20);
    push_done(0);
    pulse(1'b0, 1'b1, 4'd6);
    wait_idle("hole 6 as 0", 20);
    push_mole(5);
    push_done(529);
    pulse(1'b0, 1'b1, 4'd5);
    wait_idle("mole5", 600);
    push_done(0);
    pulse(1'b0, 1'b1, 4'd5);
    wait_idle("same 5", 20);
    push_erase(5);
    push_done(961);
    pulse(1'b0, 1'b1, 4'd0);
    wait_idle("clear 5", 1100);

    // Two hole requests during a redraw: only the last is drawn.
    push_bg();
    push_done(BGN);
    push_mole(4);
    push_done(529);
    pulse(1'b1, 1'b0, 4'd0);
    repeat (100) @(negedge clk);
    pulse(1'b0, 1'b1, 4'd2);
    repeat (50) @(negedge clk);
    pulse(1'b0, 1'b1, 4'd4);
    wait_idle("queued holes", BGN + 800);
    check("pix 50,8 hole2 untouched", fb[8][50], 1);
    check("pix 126,8 mole4", fb[8][126], 6);

    // start while the mole is being drawn: redraw then mole again.
    push_erase(4);
    push_mole(2);
    push_done(1490);
    push_bg();
    push_mole(2);
    push_done(BGN + 529);
    pulse(1'b0, 1'b1, 4'd2);
    repeat (1100) @(negedge clk);
    check("in mole phase color", bus.color, 6);
    pulse(1'b1, 1'b0, 4'd0);
    wait_idle("start during mole", BGN + 3000);
    check("pix 72,30 mole2", fb[30][72], 6);

    // Simultaneous start and hole: no erase, redraw then mole 1.
    push_bg();
    push_mole(1);
    push_done(BGN + 529);
    pulse(1'b1, 1'b1, 4'd1);
    wait_idle("start+hole1", BGN + 700);
    check("pix 12,8 mole1", fb[8][12], 6);
    check("pix 34,30 mole1", fb[30][34], 6);
    check("pix 50,8 old mole gone", fb[8][50], 1);
    check("final busy", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
